uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive core fed directly by the two-flop input synchronizer's output. Detects the start bit on the synchronized line, times each bit with a mid-bit sample, shifts in an LSB-first data word, checks the stop bit and presents the word with a ready flag. It also provides overrun and framing error flags to the register/bus side.

## Interface
- `DATA_BITS`, default 8: data bits per frame. Legal range 5–9.
- `CLKS_PER_BIT`, default 10: clk cycles per serial bit. Must be even and ≥ 4.
- `clk` in 1: system clock. All logic is on the rising edge.
- `n_rst` in 1: reset, asynchronous and active-low.
- `serial_in` in 1: synchronized serial line. Idle-high.
- `data_read` in 1: single-cycle pulse. Consumer has taken `rx_data`.
- `rx_data` out `DATA_BITS`: last received word.
- `data_ready` out 1: `rx_data` holds an unread word.
- `overrun_error` out 1: a word was overwritten before it was read.
- `framing_error` out 1: the last frame's stop bit sampled 0.
- `parity_error` out 1: parity mismatch on the last frame. Tied 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- Edge detector: `prev` register, reset value 1. A start edge is `prev==1 && serial_in==0` while in IDLE.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, LOAD.
- **IDLE**
  - On a start edge: clear the bit timer and bit counter, clear `framing_error` and `parity_error`, go to START.
- **START**
  - After `CLKS_PER_BIT/2` cycles, sample `serial_in`.
  - Sample is 1 (glitch): return to IDLE and set no flags.
  - Sample is 0: go to DATA.
- **DATA**
  - Every `CLKS_PER_BIT` cycles, sample `serial_in` and shift it into the MSB of the shift register, right-shifting (LSB-first line order).
  - After `DATA_BITS` samples, go to PARITY or STOP.
- **PARITY**
  - After `CLKS_PER_BIT` cycles, sample the parity bit.
  - Compute XOR(data bits, parity bit); a nonzero result sets `parity_error`.
  - Go to STOP.
- **STOP**
  - After `CLKS_PER_BIT` cycles, sample `serial_in`.
  - Sample 1: go to LOAD.
  - Sample 0: set `framing_error`, discard the word, go to IDLE; `rx_data` and `data_ready` are unchanged.
- **LOAD** (one cycle)
  - `rx_data <= shift`; `data_ready <= 1`.
  - If `data_ready` was already 1 and `data_read` is not asserted this cycle, set `overrun_error`.
  - Go to IDLE.
- **data_read**
  - Clears `data_ready` and `overrun_error` on the next edge.
  - If it coincides with LOAD, LOAD wins: `data_ready=1` and `overrun_error` is not set.
  - When `data_ready==0` it has no effect.
- **Error flags**
  - `framing_error` and `parity_error` are sticky until the next accepted start edge.
  - They are not cleared by `data_read`.
- **Line activity**
  - `serial_in` activity outside IDLE does not restart the frame.
  - A new start edge is recognised in IDLE one cycle after STOP/LOAD.
- **Reset** (asserted at any time, including mid-frame)
  - State IDLE, timer 0, bit counter 0, shift register 0, `prev=1`.
  - `rx_data=0`, `data_ready=0`, all error flags 0.
  - A partial frame is lost.

## Timing
- Edge detected at cycle E (the cycle in which FSM is IDLE and the edge condition holds).
- Start sample at E+`CLKS_PER_BIT/2`.
- Data bit k (k=0..DATA_BITS-1) sampled at E+`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`.
- Stop sample at E+`CLKS_PER_BIT/2`+(`DATA_BITS`+1+p)·`CLKS_PER_BIT`, where p=1 with parity, else 0.
- `data_ready` rises one cycle after a good stop sample.
- Bit timer width `$clog2(CLKS_PER_BIT)`; it wraps to 0 on every sample. Bit counter width `$clog2(DATA_BITS+1)`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state; a frame is start + data + even-parity + stop.
  - `parity_error` is driven as described in Operation.
  - A word with a parity error is still loaded.
- Not defined:
  - No PARITY state; the frame is start + data + stop.
  - `parity_error` is constant 0.

## Structure
- Package `uart_rx_pkg`: `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, LOAD) and default-parameter localparams.
- Sub-module `rx_bit_timer`: loadable counter.
  - Inputs: clear, enable, `half` select.
  - Output: one-cycle `sample_tick` at the half-bit or full-bit count.
- FSM, shift register, edge detector and flags stay in `uart_rx_core`.

## Test plan
All cases use `CLKS_PER_BIT=10`, `DATA_BITS=8`, no parity.
1. Assert `n_rst=0` mid-frame with `data_ready=1` → next cycle all outputs 0, FSM IDLE; a frame sent after release is received correctly.
2. Frame 0xA5 with stop=1 → `rx_data=0xA5`, `data_ready=1` at E+96; `data_read` pulse → `data_ready=0` next cycle.
3. `serial_in` low for 3 cycles, then high → return to IDLE at E+5; `data_ready`, `framing_error` and `rx_data` unchanged.
4. Frame 0x3C with stop=0 → `framing_error=1` at E+96, `data_ready` stays 0, `rx_data` keeps its old value; the next start edge clears `framing_error`.
5. Frames 0x11 then 0x22 with no `data_read` → `rx_data=0x22`, `overrun_error=1`; a `data_read` pulse clears `data_ready` and `overrun_error` together.
6. `data_read` asserted in the LOAD cycle of 0x5A while `data_ready=1` → `data_ready=1`, `overrun_error=0`, `rx_data=0x5A`.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and default parameters for the UART receive core.
//   rx_state_t           receive FSM state encoding
//   DEFAULT_DATA_BITS    default data bits per frame
//   DEFAULT_CLKS_PER_BIT default clk cycles per serial bit
package uart_rx_pkg;

    localparam int unsigned DEFAULT_DATA_BITS    = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        LOAD   = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, consumer handshake and status flags of the receive core.
//   serial_in     synchronized serial line (idle high)
//   data_read     consumer has taken rx_data (single-cycle pulse)
//   rx_data       last received word
//   data_ready    rx_data holds an unread word
//   overrun_error word overwritten before it was read
//   framing_error last frame's stop bit sampled 0
//   parity_error  parity mismatch on the last frame
// master: the receive core; slave: the line/consumer side.
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
);
    logic                 serial_in;
    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 overrun_error;
    logic                 framing_error;
    logic                 parity_error;

    modport master (
        input  serial_in,
        input  data_read,
        output rx_data,
        output data_ready,
        output overrun_error,
        output framing_error,
        output parity_error
    );

    modport slave (
        output serial_in,
        output data_read,
        input  rx_data,
        input  data_ready,
        input  overrun_error,
        input  framing_error,
        input  parity_error
    );
endinterface

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-period counter producing a one-cycle registered sample_tick.
//   clk, n_rst   clock, async active-low reset
//   clear        force count to 0 and suppress the tick
//   enable       count while high
//   half         1: tick after CLKS_PER_BIT/2 cycles, 0: after CLKS_PER_BIT cycles
//   sample_tick  high for one cycle at the sample point; count wraps to 0 then
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    input  logic half,
    output logic sample_tick
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    // Tick is registered, so it is armed one count before the sample count.
    localparam logic [CNT_W-1:0] HALF_PRE = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] FULL_PRE = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pre_sel;

    assign pre_sel = half ? HALF_PRE : FULL_PRE;

    // Counter and tick register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
        end else if (clear) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
        end else if (enable) begin
            cnt         <= sample_tick ? '0 : cnt + CNT_W'(1);
            sample_tick <= !sample_tick && (cnt == pre_sel);
        end else begin
            sample_tick <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver fed by a synchronized serial line. Detects the
// start edge, samples each bit mid-period, shifts in an LSB-first word, checks
// the stop bit and presents the word with ready/overrun/framing flags.
//   clk, n_rst   clock, async active-low reset
//   bus          uart_rx_if.master (serial_in, data_read in; rx_data and flags out)
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit between
// data and stop; otherwise parity_error is tied 0.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input logic       clk,
    input logic       n_rst,
    uart_rx_if.master bus
);
    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 prev;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 data_ready_q;
    logic                 overrun_q;
    logic                 framing_q;
    logic                 sample_tick;

    logic start_edge;
    logic timer_clr;
    logic timer_en;
    logic timer_half;
    logic shift_en;
    logic load_en;
    logic framing_set;
`ifdef UART_RX_PARITY_EN
    logic parity_q;
    logic parity_chk;
`endif

    assign start_edge = (state == IDLE) && prev && !bus.serial_in;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (timer_clr),
        .enable      (timer_en),
        .half        (timer_half),
        .sample_tick (sample_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_edge) state_next = START;
            START: if (sample_tick) state_next = bus.serial_in ? IDLE : DATA;
            DATA: begin
                if (sample_tick && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (sample_tick) state_next = STOP;
`endif
            STOP:  if (sample_tick) state_next = bus.serial_in ? LOAD : IDLE;
            LOAD:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        timer_half  = 1'b0;
        shift_en    = 1'b0;
        load_en     = 1'b0;
        framing_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_chk  = 1'b0;
`endif
        case (state)
            IDLE:  timer_clr = 1'b1;
            START: begin
                timer_en   = 1'b1;
                timer_half = 1'b1;
            end
            DATA: begin
                timer_en = 1'b1;
                shift_en = sample_tick;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                timer_en   = 1'b1;
                parity_chk = sample_tick;
            end
`endif
            STOP: begin
                timer_en    = 1'b1;
                framing_set = sample_tick && !bus.serial_in;
            end
            LOAD:  load_en = 1'b1;
            default: timer_clr = 1'b1;
        endcase
    end

    // Edge detector, shift register and bit counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev    <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            prev <= bus.serial_in;
            if (start_edge) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift   <= {bus.serial_in, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    // Output word and status flags; a LOAD coinciding with data_read leaves
    // the word ready and raises no overrun.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            framing_q    <= 1'b0;
        end else begin
            if (load_en) begin
                rx_data_q    <= shift;
                data_ready_q <= 1'b1;
            end else if (bus.data_read) begin
                data_ready_q <= 1'b0;
            end

            if (bus.data_read) overrun_q <= 1'b0;
            else if (load_en && data_ready_q) overrun_q <= 1'b1;

            if (start_edge)       framing_q <= 1'b0;
            else if (framing_set) framing_q <= 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity over data and parity bit; a mismatch still loads the word.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_q <= 1'b0;
        end else if (start_edge) begin
            parity_q <= 1'b0;
        end else if (parity_chk) begin
            parity_q <= ^{shift, bus.serial_in};
        end
    end

    assign bus.parity_error = parity_q;
`else
    assign bus.parity_error = 1'b0;
`endif

    assign bus.rx_data       = rx_data_q;
    assign bus.data_ready    = data_ready_q;
    assign bus.overrun_error = overrun_q;
    assign bus.framing_error = framing_q;
endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;
    localparam int unsigned DB  = 8;
    localparam int unsigned CPB = 10;

    logic clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: what the consumer should see.
    logic [DB-1:0] m_data;
    logic          m_ready;
    logic          m_ovr;
    logic          m_fe;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx_core #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rx_data"},       32'(bus.rx_data),       32'(m_data));
        check({tag, ".data_ready"},    32'(bus.data_ready),    32'(m_ready));
        check({tag, ".overrun_error"}, 32'(bus.overrun_error), 32'(m_ovr));
        check({tag, ".framing_error"}, 32'(bus.framing_error), 32'(m_fe));
        check({tag, ".parity_error"},  32'(bus.parity_error),  32'(0));
    endtask

    // Called right after a negedge; sends a full frame whose start edge is the
    // next posedge (E). Checks ready is still unchanged at E+95 and the result at E+96.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic rd);
        logic [DB:0] line;
        line = {d, 1'b0};
        m_fe = 1'b0;
        for (int i = 0; i <= DB; i++) begin
            bus.serial_in = line[i];
            repeat (CPB) @(posedge clk);
            @(negedge clk);
        end
        bus.serial_in = stop_bit;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pre_load.data_ready", 32'(bus.data_ready), 32'(m_ready));
        bus.data_read = rd;
        @(posedge clk);
        @(negedge clk);
        bus.data_read = 1'b0;
        if (stop_bit) begin
            if (m_ready) m_ovr = !rd;
            m_data  = d;
            m_ready = 1'b1;
        end else begin
            m_fe = 1'b1;
            if (rd && m_ready) begin
                m_ready = 1'b0;
                m_ovr   = 1'b0;
            end
        end
        check_all("frame");
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.serial_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Three-cycle low pulse: start sample sees 1, receiver is back in IDLE at E+5.
    task automatic glitch();
        bus.serial_in = 1'b0;
        m_fe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("glitch");
    endtask

    task automatic read_pulse();
        bus.data_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.data_read = 1'b0;
        if (m_ready) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
        check_all("read");
    endtask

    initial begin
        logic [DB-1:0] rd_data;
        logic          rd_stop;
        logic          rd_rd;

        n_rst         = 1'b0;
        bus.serial_in = 1'b1;
        bus.data_read = 1'b0;
        m_data = '0; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        n_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Good frame, then consumer read.
        send_frame(8'hA5, 1'b1, 1'b0);
        read_pulse();

        // Glitch with a word pending, then an immediate frame (overrun).
        send_frame(8'hC3, 1'b1, 1'b0);
        glitch();
        send_frame(8'h4B, 1'b1, 1'b0);
        read_pulse();

        // Bad stop bit: framing error, word kept; next start edge clears it.
        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        read_pulse();

        // data_read coinciding with LOAD while a word is pending.
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1);

        // Reset mid-frame with data_ready set.
        bus.serial_in = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        m_data = '0; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        check_all("mid_reset");
        bus.serial_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        send_frame(8'h96, 1'b1, 1'b0);

        // Randomized frames against the reference state.
        for (int i = 0; i < 12; i++) begin
            rd_data = DB'($urandom);
            rd_stop = ($urandom_range(0, 3) != 0);
            rd_rd   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) glitch();
            send_frame(rd_data, rd_stop, rd_rd);
            if ($urandom_range(0, 1) == 1) read_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
